seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed BCD-to-7-segment driver for NUM_DIGITS common-anode digits.
- Drives a single shared segment bus plus one anode line per digit.
- Adds over the static per-digit decoders: a digit scan timer, a double-buffered display latch, leading-zero suppression, per-digit blink and blank control, decimal points, and anti-ghosting dead time.
- Sits between the timer/control FSM and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 50000: clock cycles each digit is displayed, dead cycle included (>=2).
- BLINK_DIV, 25000000: clock cycles per blink half-period (>=2).
- ACTIVE_LOW, 1: 1 = segments, dp and anodes driven low-active; 0 = high-active.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- update  in  1  single-cycle strobe; loads all display inputs into the shadow registers
- digits_bcd  in  4*NUM_DIGITS  BCD per digit; digit 0 = LSBs = rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blank_mask  in  NUM_DIGITS  1 = digit forced dark
- blink_en  in  NUM_DIGITS  1 = digit blinks
- lz_suppress  in  1  1 = suppress leading zeros
- seg_out  out  7  segments {a,b,c,d,e,f,g}; bit6 = a, bit0 = g
- dp_out  out  1  decimal point of the active digit
- an_out  out  NUM_DIGITS  anode enables, one-hot or all-off
- digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently scanned

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - seg_out, dp_out and an_out all inactive: 7'b1111111, 1, all ones when ACTIVE_LOW = 1.
  - digit_idx = 0; scan and blink counters = 0; blink phase = on.
  - Shadow registers: digits = 0, masks = 0, lz_suppress = 0.
- Shadow latch:
  - On the clock edge where update = 1, all inputs are captured.
  - Display logic uses only shadow values; inputs are ignored when update = 0.
- Scan timer:
  - Counts 0..SCAN_DIV-1, then wraps.
  - At wrap, digit_idx advances idx+1, wrapping from NUM_DIGITS-1 to 0.
- Dead time:
  - The first cycle of every digit slot (count == 0) drives an_out all-off.
  - Anode of digit_idx is active for the remaining SCAN_DIV-1 cycles.
- Registered outputs:
  - seg_out, dp_out and an_out change exactly one cycle after the counter state that selects them.
  - Segments and anode always switch on the same edge.
- Decode, active-high before polarity is applied:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110010, 8 = 1111111, 9 = 1111011
  - Codes 10..15 decode to blank.
  - When ACTIVE_LOW = 1, the output is the bitwise inverse of these codes.
- Leading-zero suppression (lz_suppress = 1):
  - Scanning from digit NUM_DIGITS-1 downward, each zero digit is blank until the first nonzero digit.
  - Digit 0 is never suppressed, so all-zero shows "0".
  - dp of a suppressed digit still shows if requested.
- Blink:
  - Free-running counter toggles the blink phase every BLINK_DIV cycles.
  - In the off phase, digits with blink_en = 1 have segments and dp dark; the anode still scans.
- Priority, highest first: reset > blank_mask > blink-off > leading-zero suppression > normal decode.
- Simultaneous update and digit switch: the new digit shows the newly latched values.
- An update strobe held high for several cycles re-latches every cycle; this is legal.

Decomposition:
- Package seg7_pkg holds:
  - Active-high segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - Function bcd_to_seg.
  - Function apply_polarity.
- Sub-module seg7_decode (combinational; BCD in, 7-bit active-high code out) is instantiated once, on the selected digit.
- Top-level holds the scan counter, blink counter, shadow registers, suppression logic and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=1):
- Reset assert mid-scan, then release -> outputs inactive immediately, digit_idx = 0; first active anode an_out = 4'b1110 appears 2 cycles after release.
- update with digits 1,2,3,4 (digit 0 = 4), no masks -> cyclic pattern: 1 dead cycle with an_out = 1111, then 3 cycles of digit i with seg_out = inverse of its code (digit 0 shows 7'b1001100).
- lz_suppress = 1 with value 0,0,4,0 (msb first) -> digits 3 and 2 dark, digit 1 = 7'b1001100, digit 0 = 7'b0000001; all zeros -> only digit 0 lit with 7'b0000001.
- blink_en = 4'b0001, dp_in = 4'b0001 -> digit 0 segments and dp lit for 16 cycles, dark for 16 cycles, repeating; other digits unaffected.
- Inputs change without update -> display unchanged; update coinciding with digit wrap -> new digit shows the new value on the first lit cycle.
- blank_mask = 4'b1000 together with blink and lz active; BCD code 4'hC on digit 1 -> digit 3 always dark, digit 1 shows 7'b1111111.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment encodings and helpers for the multiplexed 7-segment driver.
// Codes are active-high {a,b,c,d,e,f,g}; board polarity is applied at the pins.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal codes render dark rather than as hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [6:0] apply_polarity(input logic [6:0] code, input logic active_low);
        return active_low ? ~code : code;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder for the currently scanned digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow latch, scan timer with dead cycle,
// blink, blanking and leading-zero suppression, all outputs registered together.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          update,
    input  logic [4*NUM_DIGITS-1:0]       digits_bcd,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic [NUM_DIGITS-1:0]         blink_en,
    input  logic                          lz_suppress,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam int   SCAN_W  = $clog2(SCAN_DIV);
    localparam int   BLINK_W = $clog2(BLINK_DIV);
    localparam logic POL     = (ACTIVE_LOW != 0);

    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic                  r_blink_on;

    logic [3:0]            r_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_dp;
    logic [NUM_DIGITS-1:0] r_blank;
    logic [NUM_DIGITS-1:0] r_blink;
    logic                  r_lz;

    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic [NUM_DIGITS-1:0] r_an;

    logic [NUM_DIGITS-1:0] w_is_zero;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic [3:0]            w_sel_bcd;
    logic [6:0]            w_dec_seg;
    logic [6:0]            w_seg_hi;
    logic                  w_dp_hi;
    logic [NUM_DIGITS-1:0] w_an_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= 4'd0;
            r_dp    <= '0;
            r_blank <= '0;
            r_blink <= '0;
            r_lz    <= 1'b0;
        end else if (update) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= digits_bcd[4*i +: 4];
            r_dp    <= dp_in;
            r_blank <= blank_mask;
            r_blink <= blink_en;
            r_lz    <= lz_suppress;
        end
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign w_is_zero[gi] = (r_digits[gi] == 4'd0);
        if (gi == 0) begin : g_lsd
            assign w_lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz_blank[gi] = r_lz & (&w_is_zero[NUM_DIGITS-1:gi]);
        end
    end

    assign w_sel_bcd = r_digits[r_digit_idx];

    seg7_decode u_decode (
        .i_bcd (w_sel_bcd),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        w_seg_hi = w_dec_seg;
        w_dp_hi  = r_dp[r_digit_idx];
        w_an_hi  = '0;
        if (r_scan_cnt == '0) begin
            // Dead cycle: everything dark while the segment bus settles.
            w_seg_hi = SEG_BLANK;
            w_dp_hi  = 1'b0;
        end else begin
            w_an_hi[r_digit_idx] = 1'b1;
            if (r_blank[r_digit_idx] || (r_blink[r_digit_idx] && !r_blink_on)) begin
                w_seg_hi = SEG_BLANK;
                w_dp_hi  = 1'b0;
            end else if (w_lz_blank[r_digit_idx]) begin
                w_seg_hi = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= {7{POL}};
            r_dp_out <= POL;
            r_an     <= {NUM_DIGITS{POL}};
        end else begin
            r_seg    <= apply_polarity(w_seg_hi, POL);
            r_dp_out <= w_dp_hi ^ POL;
            r_an     <= w_an_hi ^ {NUM_DIGITS{POL}};
        end
    end

    assign seg_out   = r_seg;
    assign dp_out    = r_dp_out;
    assign an_out    = r_an;
    assign digit_idx = r_digit_idx;

endmodule
